fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, pushes returned words into
// the instruction buffer, parks a word when the buffer is full, and squashes stale responses on redirect.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  output logic                  buf_write_en,
  output logic [INST_WIDTH-1:0] buf_data,
  output logic [ADDR_WIDTH-1:0] buf_pc,
  input  logic                  buf_is_full,
  output logic [ADDR_WIDTH-1:0] fetch_pc
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   next_pc;
  logic [INST_WIDTH-1:0]   hold_q, next_hold;
  logic                    write_raw;
  logic [ADDR_WIDTH-1:0]   pc_plus4;

  assign pc_plus4 = fetch_pc + ADDR_WIDTH'(4);

  // Outputs are gated by reset so nothing leaks out while reset is held.
  assign imem_req_valid = (state == FETCH) & ~stall & ~redirect_valid & ~reset;
  assign imem_req_addr  = fetch_pc;
  assign buf_pc         = fetch_pc;
  assign buf_write_en   = write_raw & ~buf_is_full & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      hold_q   <= '0;
    end else begin
      state    <= next_state;
      fetch_pc <= next_pc;
      hold_q   <= next_hold;
    end
  end

  // Redirect outranks every other event; a redirect while a request is still
  // in flight sends us to DISCARD so the stale beat is swallowed.
  always_comb begin
    next_state = state;
    next_pc    = fetch_pc;
    next_hold  = hold_q;
    write_raw  = 1'b0;
    buf_data   = '0;
    case (state)
      FETCH: begin
        if (redirect_valid) begin
          next_pc = redirect_pc;
        end else if (imem_req_valid && imem_req_ready) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          next_pc    = redirect_pc;
          next_state = imem_resp_valid ? FETCH : DISCARD;
        end else if (imem_resp_valid) begin
          if (buf_is_full) begin
            next_hold  = imem_resp_data;
            next_state = HOLD;
          end else begin
            write_raw  = 1'b1;
            buf_data   = imem_resp_data;
            next_pc    = pc_plus4;
            next_state = FETCH;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          next_pc    = redirect_pc;
          next_state = FETCH;
        end else if (!buf_is_full) begin
          write_raw  = 1'b1;
          buf_data   = hold_q;
          next_pc    = pc_plus4;
          next_state = FETCH;
        end
      end
      DISCARD: begin
        if (redirect_valid) begin
          next_pc = redirect_pc;
        end else if (imem_resp_valid) begin
          next_state = FETCH;
        end
      end
      default: next_state = FETCH;
    endcase
    if (reset) begin
      buf_data = '0;
    end
  end

endmodule
